updown_game_ctrl: RTL and testbench

Round controller for the up/down number-guessing game. Sits directly downstream of the 7-bit LFSR random source, which supplies `random[6:0]`. It does four things:
- latches a secret target at round start;
- accepts player guesses from the debounced input stage;
- answers each guess with an up/down/correct hint;
- tracks remaining attempts and ends the round as a win or a loss.

Its outputs drive the display/LED stage.

---
 rtl/updown_game_ctrl_pkg.sv | 10 +
 rtl/updown_game_ctrl_if.sv | 25 ++
 rtl/updown_game_ctrl.sv | 61 ++++++
 tb/tb_updown_game_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/updown_game_ctrl_pkg.sv
// updown_pkg: shared state encoding and value width for the up/down guessing game
package updown_pkg;
   localparam int VAL_W = 7;
   localparam int RANGE_MAX_DEFAULT = 99;
   typedef enum logic [2:0] {IDLE, LOAD, PLAY, WIN, LOSE} state_t;
   // Out-of-range random values fold down by one full range instead of wrapping
   function automatic logic [VAL_W-1:0] map_target(logic [VAL_W-1:0] r, logic [VAL_W-1:0] rmax);
      return r <= rmax ? r : r - rmax - VAL_W'(1);
   endfunction
endpackage

// File: rtl/updown_game_ctrl_if.sv
// updown_game_ctrl_if: player/random inputs and display outputs of the round controller
interface updown_game_ctrl_if;
   import updown_pkg::*;
   logic [VAL_W-1:0] random;
   logic [VAL_W-1:0] guess;
   logic [VAL_W-1:0] target_reveal;
   logic start;
   logic guess_valid;
   logic hint_up;
   logic hint_down;
   logic hint_correct;
   logic guess_reject;
   logic playing;
   logic game_win;
   logic game_lose;
   logic [3:0] tries_left;
   modport master(
      output random, start, guess, guess_valid,
      input hint_up, hint_down, hint_correct, guess_reject, tries_left, playing, game_win, game_lose, target_reveal
   );
   modport slave(
      input random, start, guess, guess_valid,
      output hint_up, hint_down, hint_correct, guess_reject, tries_left, playing, game_win, game_lose, target_reveal
   );
endinterface

// File: rtl/updown_game_ctrl.sv
// updown_game_ctrl: round FSM latching a target, grading guesses and counting attempts
module updown_game_ctrl
   import updown_pkg::*;
#(
   parameter int MAX_TRIES = 7,
   parameter int RANGE_MAX = RANGE_MAX_DEFAULT
) (
   input logic clk,
   input logic reset,
   updown_game_ctrl_if.slave bus
);
   localparam logic [VAL_W-1:0] RMAX = VAL_W'(RANGE_MAX);
   localparam logic [3:0] TMAX = 4'(MAX_TRIES);
   state_t state, nxt;
   logic [VAL_W-1:0] target;
   logic take, in_range, accept, hit;
   // start outranks a same-cycle guess, so a guess is only taken without start
   assign take = state == PLAY && !bus.start && bus.guess_valid;
   assign in_range = bus.guess <= RMAX;
   assign accept = take && in_range;
   assign hit = bus.guess == target;
   always_comb
      nxt = (bus.start && state != LOAD) ? LOAD :
            state == LOAD ? PLAY :
            (accept && hit) ? WIN :
            (accept && bus.tries_left == 4'd1) ? LOSE : state;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         target <= '0;
         bus.tries_left <= '0;
         bus.hint_up <= 1'b0;
         bus.hint_down <= 1'b0;
         bus.hint_correct <= 1'b0;
         bus.guess_reject <= 1'b0;
         bus.playing <= 1'b0;
         bus.game_win <= 1'b0;
         bus.game_lose <= 1'b0;
         bus.target_reveal <= '0;
      end else begin
         state <= nxt;
         bus.playing <= nxt == PLAY;
         bus.game_win <= nxt == WIN;
         bus.game_lose <= nxt == LOSE;
         bus.target_reveal <= (nxt == WIN || nxt == LOSE) ? target : '0;
         bus.guess_reject <= take && !in_range;
         if (state == LOAD)
            target <= map_target(bus.random, RMAX);
         if (nxt == LOAD || state == LOAD) begin
            bus.tries_left <= TMAX;
            bus.hint_up <= 1'b0;
            bus.hint_down <= 1'b0;
            bus.hint_correct <= 1'b0;
         end else if (accept) begin
            bus.tries_left <= bus.tries_left - 4'd1;
            bus.hint_up <= bus.guess < target;
            bus.hint_down <= bus.guess > target;
            bus.hint_correct <= hit;
         end
      end
endmodule

// File: tb/tb_updown_game_ctrl.sv
// tb_updown_game_ctrl: vector table, corner sequences and random play against a round model
module tb_updown_game_ctrl;
   localparam int MAXT = 7;
   localparam int RMAX = 99;
   logic clk, reset;
   int checks = 0, errors = 0;
   updown_game_ctrl_if bus();
   updown_game_ctrl #(.MAX_TRIES(MAXT), .RANGE_MAX(RMAX)) dut(.clk(clk), .reset(reset), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   // round model: flags describing where the game is, plain integers for values
   bit m_loading, m_active, m_won, m_lost, m_rej;
   int m_target, m_tries;
   bit [2:0] m_hint;
   typedef struct {
      bit st; bit gv; bit [6:0] g; bit [6:0] rnd;
      bit [3:0] tries; bit [2:0] hint; bit [2:0] ph; bit [6:0] rev; bit rej;
   } vec_t;
   vec_t vecs[18];
   task automatic model_reset();
      {m_loading, m_active, m_won, m_lost, m_rej} = '0;
      m_target = 0;
      m_tries = 0;
      m_hint = 3'b000;
   endtask
   task automatic model_step();
      int g;
      g = int'(bus.guess);
      m_rej = 1'b0;
      if (m_loading) begin
         m_target = int'(bus.random) % (RMAX + 1);
         m_loading = 1'b0;
         m_active = 1'b1;
      end else if (bus.start) begin
         {m_loading, m_active, m_won, m_lost} = 4'b1000;
         m_tries = MAXT;
         m_hint = 3'b000;
      end else if (m_active && bus.guess_valid) begin
         if (g > RMAX) m_rej = 1'b1;
         else begin
            m_tries = m_tries - 1;
            m_hint = g < m_target ? 3'b100 : g > m_target ? 3'b010 : 3'b001;
            if (g == m_target) {m_active, m_won} = 2'b01;
            else if (m_tries == 0) {m_active, m_lost} = 2'b01;
         end
      end
   endtask
   function automatic logic [17:0] dut_vec();
      return {bus.hint_up, bus.hint_down, bus.hint_correct, bus.guess_reject, bus.tries_left,
              bus.playing, bus.game_win, bus.game_lose, bus.target_reveal};
   endfunction
   function automatic logic [17:0] model_vec();
      return {m_hint, m_rej, 4'(m_tries), m_active, m_won, m_lost, (m_won || m_lost) ? 7'(m_target) : 7'd0};
   endfunction
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("model", 32'(dut_vec()), 32'(model_vec()));
   endtask
   task automatic drive(bit st, bit gv, int g, int rnd);
      bus.start = st;
      bus.guess_valid = gv;
      bus.guess = 7'(g);
      bus.random = 7'(rnd);
   endtask
   initial begin
      vecs = '{
         '{1,0,  0, 42, 7,3'b000,3'b000, 0,0},
         '{0,0,  0, 42, 7,3'b000,3'b100, 0,0},
         '{0,1, 50,  0, 6,3'b010,3'b100, 0,0},
         '{0,1, 30,  0, 5,3'b100,3'b100, 0,0},
         '{0,1, 42,  0, 4,3'b001,3'b010,42,0},
         '{0,1, 10,  0, 4,3'b001,3'b010,42,0},
         '{1,0,  0,115, 7,3'b000,3'b000, 0,0},
         '{0,0,  0,115, 7,3'b000,3'b100, 0,0},
         '{0,1,120,  0, 7,3'b000,3'b100, 0,1},
         '{0,1, 20,  0, 6,3'b010,3'b100, 0,0},
         '{0,1,120,  0, 6,3'b010,3'b100, 0,1},
         '{0,0,  0,  0, 6,3'b010,3'b100, 0,0},
         '{0,1, 15,  0, 5,3'b001,3'b010,15,0},
         '{1,0,  0, 10, 7,3'b000,3'b000, 0,0},
         '{0,0,  0, 10, 7,3'b000,3'b100, 0,0},
         '{0,1, 11,  0, 6,3'b010,3'b100, 0,0},
         '{1,1, 10,  0, 7,3'b000,3'b000, 0,0},
         '{0,1, 10, 10, 7,3'b000,3'b100, 0,0}
      };
      reset = 1'b1;
      drive(0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_state", 32'(dut_vec()), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].st, vecs[i].gv, vecs[i].g, vecs[i].rnd);
         cycle();
         chk($sformatf("vec%0d", i), 32'(dut_vec()),
             32'({vecs[i].hint, vecs[i].rej, vecs[i].tries, vecs[i].ph, vecs[i].rev}));
      end
      for (int i = 0; i < 7; i++) begin
         drive(0, 1, 11, 0);
         cycle();
         chk($sformatf("loss_tries%0d", i), 32'(bus.tries_left), 32'(6 - i));
         chk($sformatf("loss_hint%0d", i), 32'({bus.hint_up, bus.hint_down, bus.hint_correct}), 32'(3'b010));
      end
      chk("loss_end", 32'({bus.playing, bus.game_win, bus.game_lose, bus.target_reveal}), 32'({3'b001, 7'd10}));
      drive(1, 0, 0, 10);
      cycle();
      drive(0, 0, 0, 10);
      cycle();
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 11, 0);
         cycle();
      end
      drive(0, 1, 10, 0);
      cycle();
      chk("last_try_win", 32'({bus.game_win, bus.game_lose, bus.hint_correct, bus.tries_left}), 32'({3'b101, 4'd0}));
      drive(1, 0, 0, 50);
      cycle();
      drive(0, 0, 0, 50);
      cycle();
      drive(0, 1, 60, 0);
      cycle();
      drive(0, 0, 0, 0);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 chk("async_clear", 32'(dut_vec()), 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      drive(0, 1, 50, 0);
      cycle();
      chk("idle_ignores_guess", 32'(dut_vec()), 32'd0);
      for (int i = 0; i < 3000; i++) begin
         bus.start = $urandom_range(0, 39) == 0;
         bus.guess_valid = $urandom_range(0, 2) == 0;
         bus.guess = ($urandom_range(0, 3) == 0) ? 7'(m_target) : 7'($urandom_range(0, 127));
         bus.random = 7'($urandom_range(0, 127));
         cycle();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
